prio_pending_encoder: RTL
=========================

# prio_pending_encoder

Parametrised, registered successor to the 16-to-8 priority encoder in the Tiny Tapeout user project. It captures request pulses into a sticky pending vector, presents the highest-priority pending index with a valid/ack handshake, and clears each bit only when its grant is acknowledged. Pulses therefore survive until they are served. It sits between the `ui_in`/`uio_in` request pins and the `uo_out` index/valid pins of `tt_um_priority_16_8_encode`.

## Interface
- `N_REQ`, 16: number of request lines; legal range is 2 or more.
- `IDX_W`, `$clog2(N_REQ)`: derived localparam; width of the index output.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `ena`  in  1  clock enable; when low, all registers hold and `req_i` is not sampled.
- `req_i`  in  `N_REQ`  request pulses or levels, sampled every enabled cycle.
- `clr_i`  in  1  synchronous flush of all pending requests and any current grant.
- `ack_i`  in  1  consumer accepts the presented index.
- `idx_o`  out  `IDX_W`  granted index; registered.
- `valid_o`  out  1  `idx_o` is meaningful; registered.
- `pend_o`  out  `N_REQ`  pending vector; registered.

## Operation
- Reset values: `idx_o`=0, `valid_o`=0, `pend_o`=0, FSM state=IDLE, rotate pointer=`N_REQ`-1.
- Pending update on every enabled cycle: `pend <= (pend & ~served) | req_i`.
  - `served` is one-hot of `idx_o` when `valid_o & ack_i`, otherwise 0.
  - Set dominates clear: a request for the bit being acked on the same cycle re-pends it.
- Fixed priority: the highest set index wins (MSB first).
- FSM has two states:
  - IDLE: if `pend` is non-zero, load the winner of `pend` into `idx_o`, set `valid_o`, go to HOLD. Otherwise stay; `valid_o`=0.
  - HOLD: `idx_o` and `valid_o` are stable while `ack_i`=0. Higher-priority arrivals do not preempt.
  - HOLD with `ack_i`=1: compute the winner of `pend & ~served`. If non-zero, load it and stay in HOLD (back-to-back). If zero, clear `valid_o` and go to IDLE.
  - Requests that arrive during the ack cycle are only considered from the next cycle on.
- `ack_i` while `valid_o`=0 is ignored.
- `clr_i`=1 (enabled cycle): `pend`←0, `valid_o`←0, `idx_o`←0, state←IDLE.
  - `req_i` in that cycle is discarded.
  - `clr_i` dominates `ack_i`.
- `ena`=0: nothing changes, including the response to `ack_i`/`clr_i`.
- Asserting `rst_n` low mid-grant returns all outputs to their reset values immediately, asynchronously.

## Timing
- Latency: a request sampled at edge t appears in `pend_o` after t. `valid_o`/`idx_o` for it appear after edge t+1 (2 cycles), if it is the winner.
- Throughput: one grant per cycle while `ack_i` is held high and requests remain pending.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `PRIO_ROTATE_EN` defined: rotating priority.
  - On each accepted grant of index k, the pointer becomes (k-1) mod `N_REQ`.
  - The search starts at the pointer and proceeds downward with wrap-around.
  - The pointer is unchanged when there is no ack, and resets to `N_REQ`-1.
- `PRIO_ROTATE_EN` undefined: fixed MSB-first priority. The pointer register is not built.

## Structure
- Package `prio_enc_pkg` holds the FSM state enum (IDLE, HOLD) and a `clog2`-safe index width helper.
- Sub-module `prio_find_msb`: combinational highest-set-bit finder, parametrised on `N_REQ`, with outputs index and any-set.
  - Rotate mode uses two instances: the masked vector (bits ≤ pointer) and the full vector. The masked result wins if it has any bit set.

## Test plan
- Reset: hold `rst_n`=0 with `req_i`=16'hFFFF → `idx_o`=0, `valid_o`=0, `pend_o`=0. After release, the first grant is 15.
- One-cycle pulse `req_i`=16'h8001 with `ack_i`=1 → `valid_o` rises 2 cycles later. `idx_o` shows 15 then 0, then `valid_o`=0 and `pend_o`=0.
- `ack_i`=0, pulse 16'h0010, then 16'h0100 three cycles later → `idx_o` stays 4 until ack. After the ack, `idx_o`=8 the next cycle.
- `req_i`=16'h0020 asserted on the same cycle as the ack of index 5 → `pend_o`[5] stays 1 and index 5 is granted again.
- In HOLD with `pend_o`=16'h0F00, assert `clr_i` together with `ack_i` → next cycle `valid_o`=0, `pend_o`=0, state IDLE. With `ena`=0 instead, nothing changes.
- `req_i`=16'h8002 held continuously, `ack_i`=1 → fixed build grants 15,15,15…; `PRIO_ROTATE_EN` build grants 15,1,15,1….

Source files
------------

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared FSM state type and index width helper for the pending priority encoder
package prio_enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Index width that stays at least one bit wide even for tiny request counts
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find_msb.sv
// rtl/prio_find_msb.sv - combinational highest-set-bit finder with any-set flag
module prio_find_msb
    import prio_enc_pkg::*;
#(
    parameter int N_REQ = 16,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan so the last (highest) set bit overwrites earlier hits
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_pending_encoder.sv
// rtl/prio_pending_encoder.sv - sticky pending vector with registered valid/ack grant; PRIO_ROTATE_EN selects rotating priority
module prio_pending_encoder
    import prio_enc_pkg::*;
#(
    parameter int N_REQ = 16,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req_i,
    input  logic             clr_i,
    input  logic             ack_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic [N_REQ-1:0] pend_o
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [N_REQ-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [0:0]       state_q, state_d;

    logic [N_REQ-1:0] served;
    logic [N_REQ-1:0] avail;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             grant_taken;

    // One-hot of the presented index when the consumer accepts it this cycle
    always_comb begin
        served = '0;
        if (valid_q && ack_i) begin
            served[idx_q] = 1'b1;
        end
        avail       = pend_q & ~served;
        grant_taken = ena && !clr_i && valid_q && ack_i;
    end

`ifdef PRIO_ROTATE_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] below_ptr;
    logic [IDX_W-1:0] m_idx, f_idx;
    logic             m_any, f_any;

    // Bits at or below the pointer are searched first; wrap-around falls back to the full vector
    always_comb begin
        below_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            below_ptr[i] = (i <= int'(ptr_q));
        end
        win_idx = m_any ? m_idx : f_idx;
        win_any = f_any;
    end

    prio_find_msb #(.N_REQ(N_REQ)) u_find_masked (
        .vec_i (avail & below_ptr),
        .idx_o (m_idx),
        .any_o (m_any)
    );

    prio_find_msb #(.N_REQ(N_REQ)) u_find_full (
        .vec_i (avail),
        .idx_o (f_idx),
        .any_o (f_any)
    );

    // Pointer moves just below each accepted grant so that index gets lowest priority next
    always_comb begin
        ptr_d = ptr_q;
        if (grant_taken) begin
            ptr_d = (idx_q == '0) ? IDX_W'(N_REQ - 1) : idx_q - 1'b1;
        end
    end

    // Rotate pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    prio_find_msb #(.N_REQ(N_REQ)) u_find (
        .vec_i (avail),
        .idx_o (win_idx),
        .any_o (win_any)
    );
`endif

    // Next-state logic: flush, pending accumulation and the IDLE/HOLD grant FSM
    always_comb begin
        pend_d  = pend_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        state_d = state_q;
        if (ena) begin
            if (clr_i) begin
                pend_d  = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end else begin
                // Set dominates clear: a fresh request re-pends a bit being acked
                pend_d = avail | req_i;
                case (state_q)
                    ST_IDLE: begin
                        if (win_any) begin
                            idx_d   = win_idx;
                            valid_d = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (ack_i) begin
                            if (win_any) begin
                                idx_d = win_idx;
                            end else begin
                                valid_d = 1'b0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output and state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign pend_o  = pend_q;

endmodule
